// File: rtl/multicycle_control_if.sv
// Bus bundle between the LemonPC control unit and its instruction/data memories.
// master = control unit side, slave = memory side.
interface multicycle_control_if;
   logic        inst_req;
   logic        inst_valid;
   logic [31:0] inst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic        mem_ready;

   modport master (
      output inst_req, mem_req, mem_we, mem_size,
      input  inst_valid, inst, mem_ready
   );

   modport slave (
      input  inst_req, mem_req, mem_we, mem_size,
      output inst_valid, inst, mem_ready
   );
endinterface

// File: rtl/multicycle_control.sv
// LemonPC multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with registered selects.
// Optional macro ILLEGAL_TRAP_EN: when defined, undecodable instructions halt instead of retiring as no-ops.
module multicycle_control #(
   parameter int XLEN        = 64,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_control_if.master bus,
   output logic [2:0]          imm_sel,
   output logic [3:0]          alu_sel,
   output logic                alu_a_sel,
   output logic                alu_b_sel,
   output logic                pc_sel,
   output logic                pc_we,
   output logic                rf_we,
   output logic [1:0]          wb_sel,
   output logic                ebreak_flag,
   output logic                illegal
);

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam bit HAS_DOUBLE = (XLEN == 64);
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0]       state_reg;
   logic [31:0]      inst_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_inc;
   logic             inst_req_reg;
   logic             mem_req_reg;
   logic             mem_we_reg;
   logic [1:0]       mem_size_reg;
   logic             is_mem_reg;
   logic             noop_reg;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       size_ok;

   logic [2:0] d_imm;
   logic [3:0] d_alu;
   logic       d_a;
   logic       d_b;
   logic       d_pc;
   logic [1:0] d_wb;
   logic       d_we;
   logic [1:0] d_size;
   logic       d_mem;
   logic       d_ebreak;
   logic       d_illegal;

   assign opcode  = inst_reg[6:0];
   assign funct3  = inst_reg[14:12];
   assign funct7  = inst_reg[31:25];
   assign size_ok = (funct3 == 3'b010) || (funct3 == 3'b011 && HAS_DOUBLE);
   assign cnt_inc = cnt_reg + CNT_ONE;

   assign bus.inst_req = inst_req_reg;
   assign bus.mem_req  = mem_req_reg;
   assign bus.mem_we   = mem_we_reg;
   assign bus.mem_size = mem_size_reg;

   // Illegal encodings leave every select at 0, so a no-op retire uses snpc and no writeback.
   always_comb begin
      d_imm     = 3'd0;
      d_alu     = 4'd0;
      d_a       = 1'b0;
      d_b       = 1'b0;
      d_pc      = 1'b0;
      d_wb      = 2'd0;
      d_we      = 1'b0;
      d_size    = 2'd0;
      d_mem     = 1'b0;
      d_ebreak  = 1'b0;
      d_illegal = 1'b0;
      if (inst_reg == 32'h0010_0073) begin
         d_ebreak = 1'b1;
      end else begin
         case (opcode)
            7'b0010011: begin
               if (funct3 == 3'b000) d_b = 1'b1;
               else d_illegal = 1'b1;
            end
            7'b0110011: begin
               if (funct3 != 3'b000 || funct7 != 7'd0) d_illegal = 1'b1;
            end
            7'b0110111: begin
               d_imm = 3'd3;
               d_alu = 4'd1;
               d_b   = 1'b1;
            end
            7'b0010111: begin
               d_imm = 3'd3;
               d_a   = 1'b1;
               d_b   = 1'b1;
            end
            7'b1101111: begin
               d_imm = 3'd4;
               d_a   = 1'b1;
               d_b   = 1'b1;
               d_pc  = 1'b1;
               d_wb  = 2'd2;
            end
            7'b1100111: begin
               if (funct3 == 3'b000) begin
                  d_b  = 1'b1;
                  d_pc = 1'b1;
                  d_wb = 2'd2;
               end else begin
                  d_illegal = 1'b1;
               end
            end
            7'b0000011: begin
               if (size_ok) begin
                  d_b    = 1'b1;
                  d_wb   = 2'd1;
                  d_mem  = 1'b1;
                  d_size = funct3[1:0];
               end else begin
                  d_illegal = 1'b1;
               end
            end
            7'b0100011: begin
               if (size_ok) begin
                  d_imm  = 3'd1;
                  d_b    = 1'b1;
                  d_mem  = 1'b1;
                  d_we   = 1'b1;
                  d_size = funct3[1:0];
               end else begin
                  d_illegal = 1'b1;
               end
            end
            default: d_illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_FETCH;
         inst_reg     <= 32'd0;
         cnt_reg      <= '0;
         inst_req_reg <= 1'b0;
         mem_req_reg  <= 1'b0;
         mem_we_reg   <= 1'b0;
         mem_size_reg <= 2'd0;
         is_mem_reg   <= 1'b0;
         noop_reg     <= 1'b0;
         imm_sel      <= 3'd0;
         alu_sel      <= 4'd0;
         alu_a_sel    <= 1'b0;
         alu_b_sel    <= 1'b0;
         pc_sel       <= 1'b0;
         wb_sel       <= 2'd0;
         pc_we        <= 1'b0;
         rf_we        <= 1'b0;
         ebreak_flag  <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         pc_we <= 1'b0;
         rf_we <= 1'b0;
         case (state_reg)
            S_FETCH: begin
               if (inst_req_reg && bus.inst_valid) begin
                  inst_reg     <= bus.inst;
                  inst_req_reg <= 1'b0;
                  state_reg    <= S_DECODE;
               end else begin
                  inst_req_reg <= 1'b1;
               end
            end
            S_DECODE: begin
               imm_sel      <= d_imm;
               alu_sel      <= d_alu;
               alu_a_sel    <= d_a;
               alu_b_sel    <= d_b;
               pc_sel       <= d_pc;
               wb_sel       <= d_wb;
               mem_we_reg   <= d_we;
               mem_size_reg <= d_size;
               is_mem_reg   <= d_mem;
               noop_reg     <= d_illegal;
               if (d_ebreak) begin
                  ebreak_flag <= 1'b1;
                  state_reg   <= S_HALT;
               end else if (d_illegal && TRAP_EN) begin
                  illegal   <= 1'b1;
                  state_reg <= S_HALT;
               end else begin
                  state_reg <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_mem_reg) begin
                  mem_req_reg <= 1'b1;
                  cnt_reg     <= '0;
                  state_reg   <= S_MEM;
               end else begin
                  pc_we     <= 1'b1;
                  rf_we     <= !noop_reg;
                  state_reg <= S_WB;
               end
            end
            S_MEM: begin
               if (mem_req_reg && bus.mem_ready) begin
                  mem_req_reg <= 1'b0;
                  cnt_reg     <= '0;
                  pc_we       <= 1'b1;
                  rf_we       <= !mem_we_reg;
                  state_reg   <= S_WB;
               end else if ((MEM_TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
                  // Bus error: the access is abandoned and the core parks in HALT.
                  mem_req_reg <= 1'b0;
                  cnt_reg     <= cnt_inc;
                  illegal     <= 1'b1;
                  state_reg   <= S_HALT;
               end else begin
                  cnt_reg <= cnt_inc;
               end
            end
            S_WB: begin
               inst_req_reg <= 1'b1;
               state_reg    <= S_FETCH;
            end
            S_HALT: begin
               state_reg <= S_HALT;
            end
            default: begin
               state_reg <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one XLEN=64/MEM_TIMEOUT=8 unit plus an XLEN=32 unit for the sd check.
module tb_multicycle_control;
   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   multicycle_control_if bus64();
   multicycle_control_if bus32();

   logic [2:0] imm_sel,   imm_sel32;
   logic [3:0] alu_sel,   alu_sel32;
   logic       alu_a_sel, alu_a_sel32;
   logic       alu_b_sel, alu_b_sel32;
   logic       pc_sel,    pc_sel32;
   logic       pc_we,     pc_we32;
   logic       rf_we,     rf_we32;
   logic [1:0] wb_sel,    wb_sel32;
   logic       ebreak_flag, ebreak_flag32;
   logic       illegal,   illegal32;

   multicycle_control #(.XLEN(64), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .bus(bus64),
      .imm_sel(imm_sel), .alu_sel(alu_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .pc_sel(pc_sel), .pc_we(pc_we), .rf_we(rf_we), .wb_sel(wb_sel),
      .ebreak_flag(ebreak_flag), .illegal(illegal)
   );

   multicycle_control #(.XLEN(32), .MEM_TIMEOUT(8)) dut32 (
      .clk(clk), .rst(rst), .bus(bus32),
      .imm_sel(imm_sel32), .alu_sel(alu_sel32), .alu_a_sel(alu_a_sel32), .alu_b_sel(alu_b_sel32),
      .pc_sel(pc_sel32), .pc_we(pc_we32), .rf_we(rf_we32), .wb_sel(wb_sel32),
      .ebreak_flag(ebreak_flag32), .illegal(illegal32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Wait (bounded) for inst_req, present one word for one cycle; leaves the DUT in DECODE.
   task automatic fetch(input logic [31:0] word);
      int n = 0;
      while (bus64.inst_req !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      check("inst_req_before_fetch", {31'd0, bus64.inst_req}, 32'd1);
      bus64.inst       = word;
      bus64.inst_valid = 1'b1;
      step();
      bus64.inst_valid = 1'b0;
      check("inst_req_drop", {31'd0, bus64.inst_req}, 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus64.inst_valid = 1'b0; bus64.inst = 32'd0; bus64.mem_ready = 1'b0;
      bus32.inst_valid = 1'b0; bus32.inst = 32'd0; bus32.mem_ready = 1'b0;
      step(); step();
      check("rst_inst_req", {31'd0, bus64.inst_req}, 32'd0);
      check("rst_mem_req",  {31'd0, bus64.mem_req}, 32'd0);
      check("rst_pc_we",    {31'd0, pc_we}, 32'd0);
      check("rst_rf_we",    {31'd0, rf_we}, 32'd0);
      check("rst_illegal",  {31'd0, illegal}, 32'd0);
      check("rst_ebreak",   {31'd0, ebreak_flag}, 32'd0);
      rst = 1'b0;
      step();
      check("fetch_req_after_rst", {31'd0, bus64.inst_req}, 32'd1);
      step();

      // addi x1,x0,5
      fetch(32'h0050_0093);
      step();
      check("addi_imm_sel", {29'd0, imm_sel}, 32'd0);
      check("addi_alu_sel", {28'd0, alu_sel}, 32'd0);
      check("addi_b_sel",   {31'd0, alu_b_sel}, 32'd1);
      check("addi_wb_sel",  {30'd0, wb_sel}, 32'd0);
      check("addi_pc_we_exec", {31'd0, pc_we}, 32'd0);
      step();
      check("addi_pc_we", {31'd0, pc_we}, 32'd1);
      check("addi_rf_we", {31'd0, rf_we}, 32'd1);
      step();
      check("addi_pc_we_off", {31'd0, pc_we}, 32'd0);
      check("addi_rf_we_off", {31'd0, rf_we}, 32'd0);
      check("addi_next_req",  {31'd0, bus64.inst_req}, 32'd1);

      // jal
      fetch(32'h0000_006F);
      step();
      check("jal_pc_sel",  {31'd0, pc_sel}, 32'd1);
      check("jal_wb_sel",  {30'd0, wb_sel}, 32'd2);
      check("jal_a_sel",   {31'd0, alu_a_sel}, 32'd1);
      check("jal_imm_sel", {29'd0, imm_sel}, 32'd4);
      step();
      check("jal_rf_we", {31'd0, rf_we}, 32'd1);
      step();

      // jalr x1,0(x1)
      fetch(32'h0000_80E7);
      step();
      check("jalr_pc_sel",  {31'd0, pc_sel}, 32'd1);
      check("jalr_wb_sel",  {30'd0, wb_sel}, 32'd2);
      check("jalr_a_sel",   {31'd0, alu_a_sel}, 32'd0);
      check("jalr_imm_sel", {29'd0, imm_sel}, 32'd0);
      step(); step();

      // lui x1,0x12345
      fetch(32'h1234_50B7);
      step();
      check("lui_alu_sel", {28'd0, alu_sel}, 32'd1);
      check("lui_imm_sel", {29'd0, imm_sel}, 32'd3);
      check("lui_pc_sel",  {31'd0, pc_sel}, 32'd0);
      step(); step();

      // sd x1,0(x2) with mem_ready in the 4th request cycle
      fetch(32'h0011_3023);
      step();
      check("sd_mem_we",   {31'd0, bus64.mem_we}, 32'd1);
      check("sd_mem_size", {30'd0, bus64.mem_size}, 32'd3);
      check("sd_mem_req_exec", {31'd0, bus64.mem_req}, 32'd0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus64.mem_req !== 1'b1) break;
         n++;
         bus64.mem_ready = (n == 4);
      end
      bus64.mem_ready = 1'b0;
      check("sd_mem_req_cycles", n, 32'd4);
      check("sd_pc_we", {31'd0, pc_we}, 32'd1);
      check("sd_rf_we", {31'd0, rf_we}, 32'd0);
      step();

      // ld x1,0(x1) with no mem_ready: bus error after 8 cycles
      fetch(32'h0000_B083);
      step();
      check("ld_mem_we",   {31'd0, bus64.mem_we}, 32'd0);
      check("ld_mem_size", {30'd0, bus64.mem_size}, 32'd3);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus64.mem_req !== 1'b1) break;
         n++;
      end
      check("ld_timeout_cycles", n, 32'd8);
      check("ld_timeout_illegal", {31'd0, illegal}, 32'd1);
      check("ld_timeout_pc_we", {31'd0, pc_we}, 32'd0);
      step(); step();
      check("ld_halt_inst_req", {31'd0, bus64.inst_req}, 32'd0);
      check("ld_halt_mem_req",  {31'd0, bus64.mem_req}, 32'd0);
      rst = 1'b1;
      #1;
      check("async_rst_illegal", {31'd0, illegal}, 32'd0);
      rst = 1'b0;
      step();
      check("resume_inst_req", {31'd0, bus64.inst_req}, 32'd1);

      // lw, then async reset while mem_req is high
      fetch(32'h0000_A083);
      step();
      check("lw_wb_sel", {30'd0, wb_sel}, 32'd1);
      step();
      check("lw_mem_req", {31'd0, bus64.mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_mem_req", {31'd0, bus64.mem_req}, 32'd0);
      check("async_rst_wb_sel",  {30'd0, wb_sel}, 32'd0);
      rst = 1'b0;
      step();

      // ebreak: sticky flag, inst_valid ignored, reset resumes
      fetch(32'h0010_0073);
      step();
      check("ebreak_flag",     {31'd0, ebreak_flag}, 32'd1);
      check("ebreak_illegal",  {31'd0, illegal}, 32'd0);
      bus64.inst = 32'h0050_0093;
      bus64.inst_valid = 1'b1;
      step(); step(); step();
      bus64.inst_valid = 1'b0;
      check("halt_inst_req",   {31'd0, bus64.inst_req}, 32'd0);
      check("halt_pc_we",      {31'd0, pc_we}, 32'd0);
      check("ebreak_sticky",   {31'd0, ebreak_flag}, 32'd1);
      rst = 1'b1;
      #1;
      check("halt_rst_ebreak", {31'd0, ebreak_flag}, 32'd0);
      rst = 1'b0;
      step();
      check("halt_rst_resume", {31'd0, bus64.inst_req}, 32'd1);

      // all-ones word
      fetch(32'hFFFF_FFFF);
      step();
`ifdef ILLEGAL_TRAP_EN
      check("ones_illegal", {31'd0, illegal}, 32'd1);
      step(); step();
      check("ones_halt_inst_req", {31'd0, bus64.inst_req}, 32'd0);
      check("ones_halt_pc_we",    {31'd0, pc_we}, 32'd0);
`else
      check("ones_illegal", {31'd0, illegal}, 32'd0);
      step();
      check("ones_pc_we",  {31'd0, pc_we}, 32'd1);
      check("ones_rf_we",  {31'd0, rf_we}, 32'd0);
      check("ones_pc_sel", {31'd0, pc_sel}, 32'd0);
      step();
      check("ones_next_req", {31'd0, bus64.inst_req}, 32'd1);
`endif

      // sd on the XLEN=32 unit
      check("x32_inst_req", {31'd0, bus32.inst_req}, 32'd1);
      bus32.inst = 32'h0011_3023;
      bus32.inst_valid = 1'b1;
      step();
      bus32.inst_valid = 1'b0;
      step();
`ifdef ILLEGAL_TRAP_EN
      check("x32_sd_illegal", {31'd0, illegal32}, 32'd1);
      step();
      check("x32_halt_inst_req", {31'd0, bus32.inst_req}, 32'd0);
      check("x32_halt_mem_req",  {31'd0, bus32.mem_req}, 32'd0);
`else
      check("x32_sd_illegal", {31'd0, illegal32}, 32'd0);
      check("x32_sd_mem_we",  {31'd0, bus32.mem_we}, 32'd0);
      step();
      check("x32_sd_pc_we",   {31'd0, pc_we32}, 32'd1);
      check("x32_sd_rf_we",   {31'd0, rf_we32}, 32'd0);
      check("x32_sd_mem_req", {31'd0, bus32.mem_req}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
